// File: rtl/polynomial3_arbiter.sv
// ----------------------------------------------------------------------------
// polynomial3_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer that shares one Polynomial3 evaluator
//   (y = a*x^2 + b*x + c) among N_REQ requesters.
//
//   Transaction flow, one transaction at a time:
//     IDLE  -> grant one requester and latch its {a,b,c,x}
//     ISSUE -> present the operands to the evaluator
//     WAIT  -> wait for the evaluator result
//     RESP  -> return y to the granted requester
//
//   The arbiter performs no arithmetic; operands and the result pass through
//   unmodified.
//
// Configuration macro:
//   POLY3_ARB_TIMEOUT_EN
//     Defined:   adds a WAIT-state watchdog. After TIMEOUT_CYC cycles in WAIT
//                with no result, the response is returned with resp_y = 0 and
//                resp_err = 1.
//     Undefined: WAIT holds until the result arrives and o_resp_err is 0.
//
// Parameters:
//   N_REQ        number of requesters (2..16)
//   COEF_W       width of each unsigned coefficient a, b, c
//   X_W          width of unsigned x
//   Y_W          width of result y
//   TIMEOUT_CYC  WAIT watchdog limit in cycles (only with POLY3_ARB_TIMEOUT_EN)
//
// Ports:
//   i_clk         clock; all logic is on the rising edge
//   i_rst         asynchronous active-high reset
//   i_req_valid   per-requester request valid
//   o_req_ready   per-requester request accept (one-hot or zero, IDLE only)
//   i_req_coef    {a,b,c} per requester; requester i at slice i, a is the MSB
//   i_req_x       x per requester
//   o_ev_valid    operand valid to the evaluator
//   i_ev_ready    evaluator accepts the operands
//   o_ev_coef     latched {a,b,c}
//   o_ev_x        latched x
//   i_ev_y_valid  evaluator result strobe (single cycle)
//   i_ev_y        evaluator result
//   o_resp_valid  one-hot response valid to the owner
//   i_resp_ready  per-requester response accept
//   o_resp_y      result to the owner (shared bus)
//   o_resp_err    result invalid (watchdog timeout)
//   o_busy        high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module polynomial3_arbiter #(
  parameter int N_REQ       = 4,
  parameter int COEF_W      = 12,
  parameter int X_W         = 10,
  parameter int Y_W         = 46,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic [N_REQ*3*COEF_W-1:0]   i_req_coef,
  input  logic [N_REQ*X_W-1:0]        i_req_x,
  output logic                        o_ev_valid,
  input  logic                        i_ev_ready,
  output logic [3*COEF_W-1:0]         o_ev_coef,
  output logic [X_W-1:0]              o_ev_x,
  input  logic                        i_ev_y_valid,
  input  logic [Y_W-1:0]              i_ev_y,
  output logic [N_REQ-1:0]            o_resp_valid,
  input  logic [N_REQ-1:0]            i_resp_ready,
  output logic [Y_W-1:0]              o_resp_y,
  output logic                        o_resp_err,
  output logic                        o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW3   = 3 * COEF_W;

  // Catch illegal parameter values at elaboration time.
  if ((N_REQ < 2) || (N_REQ > 16)) begin : g_bad_n_req
    $error("polynomial3_arbiter: N_REQ must be in the range 2..16");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cyc
    $error("polynomial3_arbiter: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_owner;
  logic                   r_ev_valid;
  logic [CW3-1:0]         r_ev_coef;
  logic [X_W-1:0]         r_ev_x;
  logic [N_REQ-1:0]       r_resp_valid;
  logic [Y_W-1:0]         r_resp_y;
  logic                   r_busy;

  logic                   w_any;
  logic [IDX_W-1:0]       w_winner;
  int                     w_sum;
  logic [N_REQ-1:0]       w_owner_onehot;
  logic [IDX_W-1:0]       w_rr_next;
  logic                   w_owner_resp_ready;

`ifdef POLY3_ARB_TIMEOUT_EN
  localparam int TO_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TO_CNT_W-1:0]    r_wait_cnt;
  logic                   r_resp_err;
`endif

  assign w_any = |i_req_valid;

  // Round-robin winner: first valid requester searching upward from r_rr_ptr.
  // Scanning the offsets from high to low lets the lowest offset win last.
  always_comb begin
    w_winner = '0;
    w_sum    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = (int'(r_rr_ptr) + k) % N_REQ;
      if (i_req_valid[IDX_W'(w_sum)]) begin
        w_winner = IDX_W'(w_sum);
      end else begin
        w_winner = w_winner;
      end
    end
  end

  // Request accept is combinational so the grant handshake completes in the
  // same IDLE cycle; it is held low while reset is asserted.
  always_comb begin
    o_req_ready = '0;
    if ((r_state == S_IDLE) && w_any && !i_rst) begin
      o_req_ready[w_winner] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  // Owner decode and the pointer value used after the response completes.
  always_comb begin
    w_owner_onehot     = N_REQ'(1) << r_owner;
    w_owner_resp_ready = i_resp_ready[r_owner];
    if (r_owner == IDX_W'(N_REQ - 1)) begin
      w_rr_next = '0;
    end else begin
      w_rr_next = r_owner + IDX_W'(1);
    end
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_ev_valid   <= 1'b0;
      r_ev_coef    <= '0;
      r_ev_x       <= '0;
      r_resp_valid <= '0;
      r_resp_y     <= '0;
      r_busy       <= 1'b0;
`ifdef POLY3_ARB_TIMEOUT_EN
      r_wait_cnt   <= '0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Grant handshake: the winner always sees ready, so any valid wins.
          if (w_any) begin
            r_owner    <= w_winner;
            r_ev_coef  <= i_req_coef[int'(w_winner) * CW3 +: CW3];
            r_ev_x     <= i_req_x[int'(w_winner) * X_W +: X_W];
            r_ev_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end else begin
            r_state    <= S_IDLE;
          end
        end

        S_ISSUE: begin
          if (i_ev_ready) begin
            r_ev_valid <= 1'b0;
            r_state    <= S_WAIT;
`ifdef POLY3_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end else begin
            r_state    <= S_ISSUE;
          end
        end

        S_WAIT: begin
          // A result in the same cycle the watchdog expires takes priority.
          if (i_ev_y_valid) begin
            r_resp_y     <= i_ev_y;
            r_resp_valid <= w_owner_onehot;
            r_state      <= S_RESP;
`ifdef POLY3_ARB_TIMEOUT_EN
            r_resp_err   <= 1'b0;
          end else if (r_wait_cnt == TO_LAST) begin
            r_resp_y     <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= w_owner_onehot;
            r_state      <= S_RESP;
          end else begin
            r_wait_cnt   <= r_wait_cnt + TO_CNT_W'(1);
            r_state      <= S_WAIT;
`else
          end else begin
            r_state      <= S_WAIT;
`endif
          end
        end

        S_RESP: begin
          // Only the owner's accept completes; the pointer moves past the owner.
          if (w_owner_resp_ready) begin
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
            r_rr_ptr     <= w_rr_next;
            r_state      <= S_IDLE;
`ifdef POLY3_ARB_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
          end else begin
            r_state      <= S_RESP;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_ev_valid   <= 1'b0;
          r_resp_valid <= '0;
          r_busy       <= 1'b0;
`ifdef POLY3_ARB_TIMEOUT_EN
          r_resp_err   <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign o_ev_valid   = r_ev_valid;
  assign o_ev_coef    = r_ev_coef;
  assign o_ev_x       = r_ev_x;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_y     = r_resp_y;
  assign o_busy       = r_busy;

`ifdef POLY3_ARB_TIMEOUT_EN
  assign o_resp_err   = r_resp_err;
`else
  assign o_resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_polynomial3_arbiter.sv
// ----------------------------------------------------------------------------
// tb_polynomial3_arbiter
//
// Self-checking bench for polynomial3_arbiter (N_REQ=4, TIMEOUT_CYC=8).
// Each requester carries a fixed operand set with a hand-computed y.
// The bench plays the evaluator by computing y from the operands the arbiter
// presents; the expected response is the hand-computed value for the
// requester that should have been granted.
// ----------------------------------------------------------------------------
module tb_polynomial3_arbiter;

  localparam int N_REQ       = 4;
  localparam int COEF_W      = 12;
  localparam int X_W         = 10;
  localparam int Y_W         = 46;
  localparam int TIMEOUT_CYC = 8;

  logic                      clk = 1'b0;
  logic                      i_rst;
  logic [N_REQ-1:0]          i_req_valid;
  logic [N_REQ-1:0]          o_req_ready;
  logic [N_REQ*3*COEF_W-1:0] i_req_coef;
  logic [N_REQ*X_W-1:0]      i_req_x;
  logic                      o_ev_valid;
  logic                      i_ev_ready;
  logic [3*COEF_W-1:0]       o_ev_coef;
  logic [X_W-1:0]            o_ev_x;
  logic                      i_ev_y_valid;
  logic [Y_W-1:0]            i_ev_y;
  logic [N_REQ-1:0]          o_resp_valid;
  logic [N_REQ-1:0]          i_resp_ready;
  logic [Y_W-1:0]            o_resp_y;
  logic                      o_resp_err;
  logic                      o_busy;

  always #5 clk = ~clk;

  polynomial3_arbiter #(
    .N_REQ(N_REQ), .COEF_W(COEF_W), .X_W(X_W), .Y_W(Y_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_coef(i_req_coef), .i_req_x(i_req_x),
    .o_ev_valid(o_ev_valid), .i_ev_ready(i_ev_ready),
    .o_ev_coef(o_ev_coef), .o_ev_x(o_ev_x),
    .i_ev_y_valid(i_ev_y_valid), .i_ev_y(i_ev_y),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_y(o_resp_y), .o_resp_err(o_resp_err), .o_busy(o_busy)
  );

  // Per-requester operands and hand-computed y = a*x^2 + b*x + c.
  logic [11:0] op_a [4] = '{12'd2, 12'd1, 12'd4095, 12'd0};
  logic [11:0] op_b [4] = '{12'd3, 12'd0, 12'd4095, 12'd7};
  logic [11:0] op_c [4] = '{12'd4, 12'd0, 12'd4095, 12'd9};
  logic [9:0]  op_x [4] = '{10'd5, 10'd1023, 10'd1023, 10'd100};
  logic [45:0] op_y [4] = '{46'd69, 46'd1046529, 46'd4289729535, 46'd709};

  typedef struct {
    logic [3:0]  mask;
    int          grant;
    logic [45:0] y;
  } vec_t;

  int n_checks   = 0;
  int n_errors   = 0;
  int ev_accepts = 0;

  // Counts evaluator handshakes.
  always @(posedge clk) begin
    if (o_ev_valid && i_ev_ready) ev_accepts++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int g);
    logic [3:0] v;
    v = 4'b0001;
    return v << g;
  endfunction

  function automatic logic [35:0] exp_coef(input int g);
    return {op_a[g], op_b[g], op_c[g]};
  endfunction

  function automatic logic [45:0] poly(input logic [35:0] coef, input logic [9:0] x);
    logic [63:0] a, b, c, xx;
    a  = 64'(coef[35:24]);
    b  = 64'(coef[23:12]);
    c  = 64'(coef[11:0]);
    xx = 64'(x);
    return 46'(a * xx * xx + b * xx + c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IDLE cycle: present requests, check the grant, complete the handshake.
  task automatic do_grant(input logic [3:0] mask, input int g);
    i_req_valid = mask;
    #1;
    check("idle_busy", 64'(o_busy), 64'd0);
    check("grant", 64'(o_req_ready), 64'(onehot(g)));
    tick();
  endtask

  // ISSUE: optionally stall the evaluator, then accept exactly once.
  task automatic do_issue(input int g, input int hold);
    int start;
    start = ev_accepts;
    for (int k = 0; k < hold; k++) begin
      i_ev_ready = 1'b0;
      #1;
      check("issue_hold_valid", 64'(o_ev_valid), 64'd1);
      check("issue_hold_coef", 64'(o_ev_coef), 64'(exp_coef(g)));
      check("issue_hold_x", 64'(o_ev_x), 64'(op_x[g]));
      check("issue_hold_no_ready", 64'(o_req_ready), 64'd0);
      tick();
    end
    i_ev_ready = 1'b1;
    #1;
    check("issue_valid", 64'(o_ev_valid), 64'd1);
    check("issue_coef", 64'(o_ev_coef), 64'(exp_coef(g)));
    check("issue_x", 64'(o_ev_x), 64'(op_x[g]));
    check("issue_no_ready", 64'(o_req_ready), 64'd0);
    tick();
    i_ev_ready = 1'b0;
    check("ev_accept_count", 64'(ev_accepts - start), 64'd1);
    check("wait_ev_valid_low", 64'(o_ev_valid), 64'd0);
  endtask

  // WAIT: act as the evaluator and return y from the presented operands.
  task automatic do_result();
    i_ev_y_valid = 1'b1;
    i_ev_y       = poly(o_ev_coef, o_ev_x);
    #1;
    check("wait_no_resp", 64'(o_resp_valid), 64'd0);
    check("wait_no_ready", 64'(o_req_ready), 64'd0);
    tick();
    i_ev_y_valid = 1'b0;
    i_ev_y       = '0;
  endtask

  // RESP: optionally stall (non-owners ready), then complete with the owner.
  task automatic do_resp(input int g, input logic [45:0] y, input logic err, input int stall);
    for (int k = 0; k < stall; k++) begin
      i_resp_ready = ~onehot(g);
      #1;
      check("resp_stall_valid", 64'(o_resp_valid), 64'(onehot(g)));
      check("resp_stall_y", 64'(o_resp_y), 64'(y));
      check("resp_stall_err", 64'(o_resp_err), 64'(err));
      check("resp_stall_no_ready", 64'(o_req_ready), 64'd0);
      tick();
    end
    i_resp_ready = onehot(g);
    #1;
    check("resp_valid", 64'(o_resp_valid), 64'(onehot(g)));
    check("resp_y", 64'(o_resp_y), 64'(y));
    check("resp_err", 64'(o_resp_err), 64'(err));
    check("resp_no_ready", 64'(o_req_ready), 64'd0);
    tick();
    i_resp_ready = '0;
    i_req_valid  = '0;
    check("done_resp_valid", 64'(o_resp_valid), 64'd0);
    check("done_resp_err", 64'(o_resp_err), 64'd0);
    check("done_busy", 64'(o_busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
    check({tag, "_ev_valid"}, 64'(o_ev_valid), 64'd0);
    check({tag, "_ev_coef"}, 64'(o_ev_coef), 64'd0);
    check({tag, "_ev_x"}, 64'(o_ev_x), 64'd0);
    check({tag, "_resp_valid"}, 64'(o_resp_valid), 64'd0);
    check({tag, "_resp_y"}, 64'(o_resp_y), 64'd0);
    check({tag, "_resp_err"}, 64'(o_resp_err), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [11];
    // Round-robin sequence from reset: pointer starts at 0.
    vecs[0]  = '{4'b1111, 0, 46'd69};
    vecs[1]  = '{4'b1111, 1, 46'd1046529};
    vecs[2]  = '{4'b1111, 2, 46'd4289729535};
    vecs[3]  = '{4'b1111, 3, 46'd709};
    vecs[4]  = '{4'b1111, 0, 46'd69};
    vecs[5]  = '{4'b1111, 1, 46'd1046529};
    vecs[6]  = '{4'b0001, 0, 46'd69};         // pointer 2, wraps to 0
    vecs[7]  = '{4'b1001, 3, 46'd709};        // pointer 1
    vecs[8]  = '{4'b0110, 1, 46'd1046529};    // pointer 0
    vecs[9]  = '{4'b0100, 2, 46'd4289729535}; // pointer 2
    vecs[10] = '{4'b0010, 1, 46'd1046529};    // pointer 3, wraps to 1

    i_rst        = 1'b1;
    i_req_valid  = 4'b1111;
    i_ev_ready   = 1'b0;
    i_ev_y_valid = 1'b0;
    i_ev_y       = '0;
    i_resp_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      i_req_coef[i*36 +: 36] = {op_a[i], op_b[i], op_c[i]};
      i_req_x[i*10 +: 10]    = op_x[i];
    end
    #3;
    check_all_zero("reset");
    tick();
    tick();
    i_rst       = 1'b0;
    i_req_valid = '0;

    // Back-to-back table transactions; fixed per-cycle checks pin the
    // 4-cycle grant-to-response latency.
    for (int v = 0; v < 11; v++) begin
      do_grant(vecs[v].mask, vecs[v].grant);
      do_issue(vecs[v].grant, 0);
      do_result();
      do_resp(vecs[v].grant, vecs[v].y, 1'b0, 0);
    end

    // Evaluator back-pressure in ISSUE (pointer 2).
    do_grant(4'b0100, 2);
    do_issue(2, 10);
    do_result();
    do_resp(2, op_y[2], 1'b0, 0);

    // Owner stalls the response while everyone else keeps requesting (pointer 3).
    do_grant(4'b1111, 3);
    do_issue(3, 0);
    do_result();
    do_resp(3, op_y[3], 1'b0, 5);

`ifdef POLY3_ARB_TIMEOUT_EN
    // Watchdog expiry with no result (pointer 0).
    do_grant(4'b0001, 0);
    do_issue(0, 0);
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      #1;
      check("to_wait_no_resp", 64'(o_resp_valid), 64'd0);
      check("to_wait_busy", 64'(o_busy), 64'd1);
      tick();
    end
    i_ev_y_valid = 1'b1;
    i_ev_y       = 46'h123456789;
    do_resp(0, 46'd0, 1'b1, 2);
    tick();
    i_ev_y_valid = 1'b0;
    i_ev_y       = '0;
    check("to_stale_y_dropped", 64'(o_resp_y), 64'd0);
    check("to_stale_idle", 64'(o_busy), 64'd0);

    // Result arriving in the final watchdog cycle wins (pointer 1).
    do_grant(4'b0010, 1);
    do_issue(1, 0);
    for (int k = 0; k < TIMEOUT_CYC - 1; k++) begin
      #1;
      check("to_edge_no_resp", 64'(o_resp_valid), 64'd0);
      tick();
    end
    do_result();
    do_resp(1, op_y[1], 1'b0, 0);
`else
    // Without the watchdog WAIT holds indefinitely (pointer 0).
    do_grant(4'b0001, 0);
    do_issue(0, 0);
    for (int k = 0; k < 20; k++) begin
      #1;
      check("nowd_busy", 64'(o_busy), 64'd1);
      check("nowd_no_resp", 64'(o_resp_valid), 64'd0);
      check("nowd_err", 64'(o_resp_err), 64'd0);
      tick();
    end
    do_result();
    do_resp(0, op_y[0], 1'b0, 0);
`endif

    // Reset in WAIT aborts the transaction and returns the pointer to 0.
    do_grant(4'b0010, 1);
    do_issue(1, 0);
    i_req_valid = 4'b1111;
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    i_rst        = 1'b0;
    i_req_valid  = '0;
    i_ev_y_valid = 1'b1;
    i_ev_y       = 46'h3FF;
    tick();
    i_ev_y_valid = 1'b0;
    i_ev_y       = '0;
    check("postrst_busy", 64'(o_busy), 64'd0);
    check("postrst_resp_valid", 64'(o_resp_valid), 64'd0);
    check("postrst_resp_y", 64'(o_resp_y), 64'd0);
    do_grant(4'b1111, 0);
    do_issue(0, 0);
    do_result();
    do_resp(0, op_y[0], 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
